// File: rtl/riscv_core_if_fetch_ctrl_t.sv
// Instruction-fetch controller: sequences imem requests, redirects, ID stalls and fetch faults.
// Optional fetch timeout is enabled by defining RISCV_CORE_IF_FETCH_TIMEOUT_EN.
module riscv_core_if_fetch_ctrl_t #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  MAX_WAIT = 8'd15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] r_pc_Q,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        id_stall_req,
    input  logic        imem_ack,
    input  logic        imem_err,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        ACT,
    output logic [31:0] s_if_pcin_Q,
    output logic        s_id_clear_Q,
    output logic        s_id_stall_Q,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        outstanding, outstanding_nxt;
    logic [31:0] drain_target, drain_target_nxt;
    logic [31:0] fault_pc_r, fault_pc_nxt;

    logic        req_int;
    logic        act_int;
    logic        clear_int;
    logic        stall_int;
    logic [31:0] pcin_int;
    logic        fault_go;
    logic [31:0] fault_addr;
    logic        timeout_hit;
    logic        redir_misaligned;

    assign redir_misaligned = (redir_target[1:0] != 2'b00);

    // Request is held while a request is outstanding so the memory never sees a withdrawal.
    assign req_int = (state == FETCH) ? (!id_stall_req || outstanding) : (state == DRAIN);

`ifdef RISCV_CORE_IF_FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       redir_accept;

    assign redir_accept = redir_valid && ((state == FETCH) || (state == DRAIN));
    assign timeout_hit  = req_int && !imem_ack && (wait_cnt == MAX_WAIT - 8'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (imem_ack || redir_accept) begin
            wait_cnt <= '0;
        end else if (req_int && !imem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    logic unused_max_wait;

    assign unused_max_wait = ^MAX_WAIT;
    assign timeout_hit     = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, otherwise paths that skip an assignment infer latches.
        act_int          = 1'b0;
        clear_int        = 1'b0;
        stall_int        = 1'b0;
        pcin_int         = '0;
        fault_go         = 1'b0;
        fault_addr       = '0;
        state_nxt        = state;
        drain_target_nxt = drain_target;
        fault_pc_nxt     = fault_pc_r;

        case (state)
            BOOT: begin
                act_int   = 1'b1;
                pcin_int  = RESET_PC;
                clear_int = 1'b1;
                state_nxt = FETCH;
            end

            FETCH: begin
                if (redir_valid) begin
                    if (redir_misaligned) begin
                        fault_go   = 1'b1;
                        fault_addr = redir_target;
                    end else begin
                        act_int   = 1'b1;
                        clear_int = 1'b1;
                        if (!outstanding || imem_ack) begin
                            pcin_int = redir_target;
                        end else begin
                            // Request in flight: keep the PC until its response arrives.
                            pcin_int         = r_pc_Q;
                            drain_target_nxt = redir_target;
                            state_nxt        = DRAIN;
                        end
                    end
                end else if (imem_ack && imem_err) begin
                    fault_go   = 1'b1;
                    fault_addr = r_pc_Q;
                end else if (timeout_hit) begin
                    fault_go   = 1'b1;
                    fault_addr = r_pc_Q;
                end else if (id_stall_req) begin
                    act_int   = 1'b1;
                    pcin_int  = r_pc_Q;
                    stall_int = 1'b1;
                end else if (imem_ack) begin
                    act_int  = 1'b1;
                    pcin_int = r_pc_Q + 32'd4;
                end else begin
                    act_int   = 1'b1;
                    pcin_int  = r_pc_Q;
                    clear_int = 1'b1;
                end
            end

            DRAIN: begin
                if (redir_valid && redir_misaligned) begin
                    fault_go   = 1'b1;
                    fault_addr = redir_target;
                end else if (!redir_valid && timeout_hit) begin
                    fault_go   = 1'b1;
                    fault_addr = r_pc_Q;
                end else begin
                    act_int   = 1'b1;
                    clear_int = 1'b1;
                    pcin_int  = r_pc_Q;
                    if (redir_valid) begin
                        drain_target_nxt = redir_target;
                    end
                    // The drained response is discarded; the newest target wins.
                    if (imem_ack) begin
                        pcin_int  = redir_valid ? redir_target : drain_target;
                        state_nxt = FETCH;
                    end
                end
            end

            default: begin
                state_nxt = FAULT;
            end
        endcase

        if (fault_go) begin
            state_nxt    = FAULT;
            fault_pc_nxt = fault_addr;
        end

        outstanding_nxt = req_int && !imem_ack;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= BOOT;
            outstanding  <= 1'b0;
            drain_target <= '0;
            fault_pc_r   <= '0;
        end else begin
            state        <= state_nxt;
            outstanding  <= outstanding_nxt;
            drain_target <= drain_target_nxt;
            fault_pc_r   <= fault_pc_nxt;
        end
    end

    // Outputs are forced low for the whole reset window, abandoning any request.
    assign imem_req     = !RST && req_int;
    assign imem_addr    = RST ? '0 : r_pc_Q;
    assign ACT          = !RST && act_int;
    assign s_if_pcin_Q  = RST ? '0 : pcin_int;
    assign s_id_clear_Q = !RST && clear_int;
    assign s_id_stall_Q = !RST && stall_int;
    assign fetch_fault  = !RST && (state == FAULT);
    assign fault_pc     = fault_pc_r;

endmodule

// File: tb/tb_riscv_core_if_fetch_ctrl_t.sv
// Self-checking bench for riscv_core_if_fetch_ctrl_t: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_riscv_core_if_fetch_ctrl_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 15;

    logic        CLK;
    logic        RST;
    logic [31:0] pc;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        id_stall_req;
    logic        imem_ack;
    logic        imem_err;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ACT;
    logic [31:0] s_if_pcin_Q;
    logic        s_id_clear_Q;
    logic        s_id_stall_Q;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    riscv_core_if_fetch_ctrl_t #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (8'(MAX_WAIT))
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .r_pc_Q       (pc),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .id_stall_req (id_stall_req),
        .imem_ack     (imem_ack),
        .imem_err     (imem_err),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .ACT          (ACT),
        .s_if_pcin_Q  (s_if_pcin_Q),
        .s_id_clear_Q (s_id_clear_Q),
        .s_id_stall_Q (s_id_stall_Q),
        .fetch_fault  (fetch_fault),
        .fault_pc     (fault_pc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model of the controller's observable situation.
    bit          m_boot, m_dead, m_drain, m_pend;
    logic [31:0] m_tgt, m_fpc;
    int          m_waits;
    bit          n_boot, n_dead, n_drain, n_pend;
    logic [31:0] n_tgt, n_fpc;
    int          n_waits;
    bit          e_req, e_act, e_clr, e_stl, e_flt;
    logic [31:0] e_pcin, e_addr, e_fpc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_boot  = 1'b1;
        m_dead  = 1'b0;
        m_drain = 1'b0;
        m_pend  = 1'b0;
        m_tgt   = '0;
        m_fpc   = '0;
        m_waits = 0;
    endtask

    task automatic predict();
        bit          fault_now;
        bit          timed_out;
        logic [31:0] fault_at;
        fault_now = 1'b0;
        timed_out = 1'b0;
        fault_at  = '0;
        e_req  = 1'b0;
        e_act  = 1'b0;
        e_clr  = 1'b0;
        e_stl  = 1'b0;
        e_pcin = '0;
        e_addr = pc;
        e_flt  = m_dead;
        e_fpc  = m_fpc;
        n_boot = m_boot; n_dead = m_dead; n_drain = m_drain; n_pend = m_pend;
        n_tgt  = m_tgt;  n_fpc  = m_fpc;  n_waits = m_waits;
        if (m_dead) begin
            n_pend = 1'b0;
        end else if (m_boot) begin
            e_act  = 1'b1;
            e_pcin = RESET_PC;
            e_clr  = 1'b1;
            n_boot = 1'b0;
        end else begin
            e_req = m_drain || !id_stall_req || m_pend;
            if (redir_valid) begin
                n_waits = 0;
                if (redir_target % 4 != 0) begin
                    fault_now = 1'b1;
                    fault_at  = redir_target;
                end else begin
                    e_act = 1'b1;
                    e_clr = 1'b1;
                    if (m_drain) begin
                        if (imem_ack) begin
                            e_pcin  = redir_target;
                            n_drain = 1'b0;
                        end else begin
                            e_pcin = pc;
                            n_tgt  = redir_target;
                        end
                    end else if (!m_pend || imem_ack) begin
                        e_pcin = redir_target;
                    end else begin
                        e_pcin  = pc;
                        n_tgt   = redir_target;
                        n_drain = 1'b1;
                    end
                end
            end else begin
`ifdef RISCV_CORE_IF_FETCH_TIMEOUT_EN
                if (imem_ack) n_waits = 0;
                else if (e_req) begin
                    n_waits   = m_waits + 1;
                    timed_out = (n_waits >= MAX_WAIT);
                end
`endif
                if (m_drain) begin
                    if (timed_out) begin
                        fault_now = 1'b1;
                        fault_at  = pc;
                    end else begin
                        e_act = 1'b1;
                        e_clr = 1'b1;
                        if (imem_ack) begin
                            e_pcin  = m_tgt;
                            n_drain = 1'b0;
                        end else begin
                            e_pcin = pc;
                        end
                    end
                end else if ((imem_ack && imem_err) || timed_out) begin
                    fault_now = 1'b1;
                    fault_at  = pc;
                end else if (id_stall_req) begin
                    e_act  = 1'b1;
                    e_stl  = 1'b1;
                    e_pcin = pc;
                end else if (imem_ack) begin
                    e_act  = 1'b1;
                    e_pcin = pc + 32'd4;
                end else begin
                    e_act  = 1'b1;
                    e_clr  = 1'b1;
                    e_pcin = pc;
                end
            end
            n_pend = e_req && !imem_ack;
            if (fault_now) begin
                n_dead = 1'b1;
                n_fpc  = fault_at;
            end
        end
    endtask

    task automatic compare_outputs();
        check("imem_req", 32'(imem_req), 32'(e_req));
        check("imem_addr", imem_addr, e_addr);
        check("ACT", 32'(ACT), 32'(e_act));
        check("fetch_fault", 32'(fetch_fault), 32'(e_flt));
        check("fault_pc", fault_pc, e_fpc);
        if (e_act) begin
            check("s_if_pcin_Q", s_if_pcin_Q, e_pcin);
            check("s_id_clear_Q", 32'(s_id_clear_Q), 32'(e_clr));
            check("s_id_stall_Q", 32'(s_id_stall_Q), 32'(e_stl));
        end
    endtask

    // One clock cycle: drive inputs, check the combinational response, then advance on the edge.
    task automatic step(input bit rv, input logic [31:0] tgt, input bit st, input bit ack, input bit err);
        redir_valid  = rv;
        redir_target = tgt;
        id_stall_req = st;
        imem_ack     = ack;
        imem_err     = err;
        #3;
        predict();
        compare_outputs();
        @(posedge CLK);
        m_boot = n_boot; m_dead = n_dead; m_drain = n_drain; m_pend = n_pend;
        m_tgt  = n_tgt;  m_fpc  = n_fpc;  m_waits = n_waits;
        if (e_act) pc = e_pcin;
        #1;
    endtask

    task automatic reset_cycles(input int n);
        RST = 1'b1;
        for (int i = 0; i < n; i++) begin
            redir_valid  = $urandom_range(0, 1) == 1;
            redir_target = $urandom;
            id_stall_req = $urandom_range(0, 1) == 1;
            imem_ack     = $urandom_range(0, 1) == 1;
            imem_err     = $urandom_range(0, 1) == 1;
            pc           = $urandom | 32'h1;
            #3;
            check("rst_imem_req", 32'(imem_req), 32'h0);
            check("rst_imem_addr", imem_addr, 32'h0);
            check("rst_ACT", 32'(ACT), 32'h0);
            check("rst_pcin", s_if_pcin_Q, 32'h0);
            check("rst_clear", 32'(s_id_clear_Q), 32'h0);
            check("rst_stall", 32'(s_id_stall_Q), 32'h0);
            check("rst_fetch_fault", 32'(fetch_fault), 32'h0);
            check("rst_fault_pc", fault_pc, 32'h0);
            @(posedge CLK);
            #1;
        end
        model_clear();
        RST = 1'b0;
    endtask

    initial begin
        RST          = 1'b1;
        pc           = '0;
        redir_valid  = 1'b0;
        redir_target = '0;
        id_stall_req = 1'b0;
        imem_ack     = 1'b0;
        imem_err     = 1'b0;
        model_clear();
        @(posedge CLK);
        #1;
        reset_cycles(2);

        // Boot then sequential fetch with an ack every cycle: 0, 4, 8, 12.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("seq_pc_after_boot", pc, 32'd12);

        // Redirect to 0x100, wait, redirect to 0x200 while outstanding, drain, then ack.
        step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("drain_target_pc", pc, 32'h200);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // ID stall for two cycles with ack present; same PC fetched afterwards.
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("stall_pc_held", pc, 32'h204);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("wrap_pc", pc, 32'h0);

        // Reset asserted while a request is outstanding.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset_cycles(2);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Misaligned redirect: sticky fault until reset.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h202, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, 1'b1, 1'b0);
        check("fault_pc_misaligned", fault_pc, 32'h202);
        reset_cycles(1);

        // Randomized traffic in several reset-separated rounds.
        for (int r = 0; r < 8; r++) begin
            reset_cycles(1);
            for (int i = 0; i < 60; i++) begin
                bit          rv, ack;
                logic [31:0] tgt;
                rv  = $urandom_range(0, 7) == 0;
                tgt = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                ack = $urandom_range(0, 2) != 0;
                step(rv, tgt, $urandom_range(0, 4) == 0, ack, ack && ($urandom_range(0, 24) == 0));
            end
        end

        // Long wait with no ack: fault on the MAX_WAIT-th cycle only if the timeout is built in.
        reset_cycles(1);
        for (int i = 0; i < 1000; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("long_wait_fault", 32'(fetch_fault), 32'(e_flt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
